// File: rtl/bus_arbiter_if.sv
// Bus-side signal bundle of the arbiter: module requests/grants and the bus answer lines.
// The slave modport is the arbiter's view; the master modport is the modules'/bus view.
interface bus_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int OW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] zg;
    logic            ok;
    logic            en;
    logic            pe;
    logic [NREQ-1:0] zw;
    logic [OW-1:0]   owner;
    logic            busy;
    logic            talarm;

    modport master (
        output zg, ok, en, pe,
        input  zw, owner, busy, talarm
    );

    modport slave (
        input  zg, ok, en, pe,
        output zw, owner, busy, talarm
    );
endinterface

// File: rtl/bus_arbiter.sv
// MERA-400 system-bus arbiter: grants ZW to one ZG requester and tracks the transfer
// until OK/EN/PE arrives; raises a one-cycle TALARM when no answer arrives in time.
module bus_arbiter #(
    parameter int NREQ        = 4,
    parameter int ALARM_TICKS = 250,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic         __clk,
    input  logic         clo_,
    bus_arbiter_if.slave bus
);
    localparam int OW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(ALARM_TICKS);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE, ALARM} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] zw_q, zw_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            talarm_q, talarm_d;

    logic [OW-1:0]   start;
    logic [OW:0]     sum;
    logic [OW-1:0]   cand;
    logic [OW-1:0]   win;
    logic            win_vld;
    logic            answer;
    logic            owner_req;

    // Scan from the highest offset down so the last hit is the first set index at/after start.
    always_comb begin
        start   = ROUND_ROBIN ? ptr_q : '0;
        sum     = '0;
        cand    = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (OW+1)'(k);
            if (sum >= (OW+1)'(NREQ)) begin
                sum = sum - (OW+1)'(NREQ);
            end
            cand = sum[OW-1:0];
            if (bus.zg[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign answer    = bus.ok | bus.en | bus.pe;
    assign owner_req = bus.zg[owner_q];

    always_comb begin
        state_d  = state_q;
        zw_d     = zw_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        talarm_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    zw_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    owner_d = win;
                    timer_d = '0;
                    if (ROUND_ROBIN) begin
                        ptr_d = (win == OW'(NREQ - 1)) ? '0 : win + 1'b1;
                    end
                end
            end
            GRANT: begin
                // Withdrawal beats an answer, and an answer beats a simultaneous timeout.
                if (!owner_req) begin
                    state_d = IDLE;
                    zw_d    = '0;
                    owner_d = '0;
                end else if (answer) begin
                    state_d = RELEASE;
                end else if (timer_q == TW'(ALARM_TICKS - 1)) begin
                    state_d  = ALARM;
                    talarm_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ALARM: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    zw_d    = '0;
                    owner_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                zw_d    = '0;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge __clk) begin
        if (!clo_) begin
            state_q  <= IDLE;
            zw_q     <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            timer_q  <= '0;
            talarm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            zw_q     <= zw_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            talarm_q <= talarm_d;
        end
    end

    assign bus.zw     = zw_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.talarm = talarm_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a fixed-priority and a rotating-priority instance, both with an
// 8-cycle alarm window, driven cycle by cycle with expected outputs queued per cycle.
module tb_bus_arbiter;
    localparam int NREQ  = 4;
    localparam int TICKS = 8;

    logic clk = 1'b0;
    logic clo_;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NREQ(NREQ)) if_fix ();
    bus_arbiter_if #(.NREQ(NREQ)) if_rr ();

    bus_arbiter #(.NREQ(NREQ), .ALARM_TICKS(TICKS), .ROUND_ROBIN(1'b0)) dut_fix (
        .__clk (clk),
        .clo_  (clo_),
        .bus   (if_fix)
    );

    bus_arbiter #(.NREQ(NREQ), .ALARM_TICKS(TICKS), .ROUND_ROBIN(1'b1)) dut_rr (
        .__clk (clk),
        .clo_  (clo_),
        .bus   (if_rr)
    );

    typedef struct {
        string      name;
        bit         sel;
        logic [3:0] zw;
        logic [1:0] owner;
        logic       busy;
        logic       talarm;
    } exp_t;

    typedef struct {
        string      name;
        logic       clo;
        logic [3:0] zg;
        logic       ok;
        logic       en;
        logic       pe;
        logic [3:0] zw;
        logic [1:0] owner;
        logic       busy;
        logic       talarm;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input string name, input logic clo, input logic [3:0] zg,
                                input logic ok, input logic en, input logic pe,
                                input logic [3:0] zw, input logic [1:0] owner,
                                input logic busy, input logic talarm);
        vec_t v;
        v.name = name; v.clo = clo; v.zg = zg; v.ok = ok; v.en = en; v.pe = pe;
        v.zw = zw; v.owner = owner; v.busy = busy; v.talarm = talarm;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs to the selected instance, queue the outputs required after
    // the next rising edge, then compare them one time unit after that edge.
    task automatic step(input string name, input bit sel, input logic clo, input logic [3:0] zg,
                        input logic ok, input logic en, input logic pe,
                        input logic [3:0] e_zw, input logic [1:0] e_owner,
                        input logic e_busy, input logic e_talarm);
        exp_t       e;
        logic [3:0] a_zw;
        logic [1:0] a_owner;
        logic       a_busy;
        logic       a_talarm;
        clo_      = clo;
        if_fix.zg = sel ? 4'b0000 : zg;
        if_fix.ok = sel ? 1'b0 : ok;
        if_fix.en = sel ? 1'b0 : en;
        if_fix.pe = sel ? 1'b0 : pe;
        if_rr.zg  = sel ? zg : 4'b0000;
        if_rr.ok  = sel ? ok : 1'b0;
        if_rr.en  = sel ? en : 1'b0;
        if_rr.pe  = sel ? pe : 1'b0;
        e.name = name; e.sel = sel; e.zw = e_zw; e.owner = e_owner;
        e.busy = e_busy; e.talarm = e_talarm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
            a_zw = if_rr.zw; a_owner = if_rr.owner; a_busy = if_rr.busy; a_talarm = if_rr.talarm;
        end else begin
            a_zw = if_fix.zw; a_owner = if_fix.owner; a_busy = if_fix.busy; a_talarm = if_fix.talarm;
        end
        n_tests++;
        if ({a_zw, a_owner, a_busy, a_talarm} !== {e.zw, e.owner, e.busy, e.talarm}) begin
            n_fail++;
            $display("FAIL %s: got zw=%b owner=%0d busy=%b talarm=%b, want zw=%b owner=%0d busy=%b talarm=%b",
                     e.name, a_zw, a_owner, a_busy, a_talarm, e.zw, e.owner, e.busy, e.talarm);
        end
    endtask

    initial begin
        int w;

        // name, clo_, zg, ok, en, pe -> zw, owner, busy, talarm
        add("rst",          1'b0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("fix_grant1",   1'b1, 4'b1010, 0, 0, 0, 4'b0010, 2'd1, 1, 0);
        add("fix_hold1a",   1'b1, 4'b1010, 0, 0, 0, 4'b0010, 2'd1, 1, 0);
        add("fix_hold1b",   1'b1, 4'b1010, 0, 0, 0, 4'b0010, 2'd1, 1, 0);
        add("fix_ok1",      1'b1, 4'b1010, 1, 0, 0, 4'b0010, 2'd1, 1, 0);
        add("fix_rel1",     1'b1, 4'b1010, 0, 0, 0, 4'b0010, 2'd1, 1, 0);
        add("fix_drop1",    1'b1, 4'b1000, 0, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("fix_grant3",   1'b1, 4'b1000, 0, 0, 0, 4'b1000, 2'd3, 1, 0);
        add("fix_en3",      1'b1, 4'b1001, 0, 1, 0, 4'b1000, 2'd3, 1, 0);
        add("fix_drop3",    1'b1, 4'b0001, 0, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("fix_grant0",   1'b1, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 0);
        add("fix_drop0",    1'b1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("fix_idle_ok",  1'b1, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("fix_idle",     1'b1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("rst_grant",    1'b1, 4'b1111, 0, 0, 0, 4'b0001, 2'd0, 1, 0);
        add("rst_hold",     1'b1, 4'b1111, 0, 0, 0, 4'b0001, 2'd0, 1, 0);
        add("rst_mid",      1'b0, 4'b1111, 0, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("rst_regrant",  1'b1, 4'b1111, 0, 0, 0, 4'b0001, 2'd0, 1, 0);
        add("rst_drop",     1'b1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("wd_grant2",    1'b1, 4'b0100, 0, 0, 0, 4'b0100, 2'd2, 1, 0);
        add("wd_withdraw",  1'b1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("wd_late_ok",   1'b1, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 0, 0);
        add("wd_idle",      1'b1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].name, 1'b0, vecs[i].clo, vecs[i].zg, vecs[i].ok, vecs[i].en, vecs[i].pe,
                 vecs[i].zw, vecs[i].owner, vecs[i].busy, vecs[i].talarm);
        end

        // No answer: alarm pulse exactly 8 cycles after the grant, grant held until zg drops.
        for (int i = 1; i <= 12; i++) begin
            step("timeout", 1'b0, 1'b1, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1'b1, logic'(i == 9));
        end
        step("timeout_drop", 1'b0, 1'b1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("timeout_idle", 1'b0, 1'b1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1'b0, 1'b0);

        // pe arrives in the same cycle the window would expire: answer wins, no alarm ever.
        for (int i = 1; i <= 12; i++) begin
            step("collide", 1'b0, 1'b1, 4'b0001, 0, 0, logic'(i == 9), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step("collide_drop", 1'b0, 1'b1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Rotating priority with every request held: grants 0,1,2,3,0 with a dead cycle between.
        w = 0;
        for (int g = 0; g < 5; g++) begin
            step("rr_grant",  1'b1, 1'b1, 4'b1111, 0, 0, 0, 4'b0001 << w, 2'(w), 1'b1, 1'b0);
            step("rr_answer", 1'b1, 1'b1, 4'b1111, 1, 0, 0, 4'b0001 << w, 2'(w), 1'b1, 1'b0);
            step("rr_drop",   1'b1, 1'b1, 4'b1111 & ~(4'b0001 << w), 0, 0, 0,
                 4'b0000, 2'd0, 1'b0, 1'b0);
            w = (w + 1) % NREQ;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
